mux2x32_arbiter: RTL and testbench
==================================

# mux2x32_arbiter

Round-robin arbiter that shares one 32-bit datapath between two requesters using valid/ready handshakes with burst locking. It drives the select of a MUX2X32D instance and sits between two producers (e.g. ALU result and memory load) and one consumer port (e.g. writeback bus). The grant is held for a whole burst, delimited by a LAST flag. A stalled burst is revoked after a programmable idle timeout.

## Interface
- TIMEOUT, 16: consecutive cycles with granted valid low mid-burst before the grant is revoked; legal range 1..255.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- V0  in  1  requester 0 valid.
- D0  in  32  requester 0 data.
- L0  in  1  requester 0 last beat of burst.
- R0  out  1  requester 0 ready.
- V1, D1, L1  in  1/32/1  requester 1, same as requester 0.
- R1  out  1  requester 1 ready.
- Y  out  32  output data (MUX2X32D output).
- YV  out  1  output valid.
- YL  out  1  output last.
- YR  in  1  consumer ready.
- GNT  out  2  one-hot current grant; 00 when idle.
- ERR  out  1  one-cycle pulse on timeout revoke.

## Operation
- States:
  - IDLE: no grant.
  - G0: grant to requester 0.
  - G1: grant to requester 1.
- Beat transfer: a beat transfers on a cycle where YV & YR.
- Priority pointer PTR (1 bit) names the favored requester. After every completed or revoked burst, PTR is set to the other requester.
- IDLE:
  - YV=0, R0=R1=0, Y=D0 (S=0).
  - If only one V is high, go to that G state.
  - If both are high, go to G[PTR].
  - If neither is high, stay in IDLE.
- Gn:
  - S=n, Y=Dn, YV=Vn, YL=Ln, Rn=YR, R(other)=0, GNT bit n=1.
- Burst end: a transferred beat with Ln=1 ends the burst.
  - If the other requester's V is high that cycle, go directly to G(other).
  - Otherwise go to IDLE.
- Stall timer:
  - Counter IDLECNT (8-bit) increments each cycle in Gn with Vn=0.
  - It clears on any cycle with Vn=1 and on every state entry.
  - When IDLECNT reaches TIMEOUT-1 with Vn still 0: pulse ERR, go to IDLE, toggle PTR.
- Vn=1 with YR=0 is backpressure, not a stall. It never advances IDLECNT.
- Requesters hold Dn/Ln stable while Vn & !Rn. The arbiter does not check this.

## Timing
- Reset values: state IDLE, PTR=0, IDLECNT=0, GNT=00, YV=0, YL=0, R0=R1=0, ERR=0, Y=D0.
- RST has priority over all other events, including mid-burst. On the next cycle the arbiter is in IDLE and the in-flight burst is dropped without ERR.
- Arbitration latency is 1 cycle. A V rising in IDLE gives a grant, and the data path becomes valid, on the following cycle.
- Back-to-back bursts from different requesters incur no bubble. Back-to-back bursts from the same requester incur one IDLE cycle.
- Y, YV, YL and Rn are combinational from the inputs in Gn states. The zero-latency data path is MUX2X32D only.
- GNT, ERR and state are registered.
- Single-beat burst (Ln=1 on the first beat) is legal and ends in that cycle.
- Simultaneous burst end and timeout cannot occur, because the transfer requires Vn=1.
- TIMEOUT=1 revokes on the first cycle with Vn low.

## Structure
- Package mux2x32_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_G0=2'd1, ST_G1=2'd2;
  - the 32-bit data width constant;
  - the default TIMEOUT.
- One sub-module: the existing MUX2X32D, instantiated with A0=D0, A1=D1, S=grant index, Y=Y.
- FSM, PTR and IDLECNT live in mux2x32_arbiter itself.

## Test plan
- Reset, then V0=1, D0=0xFFFFFFFF, L0=1, YR=1 → next cycle GNT=01, Y=0xFFFFFFFF, YV=1, R0=1. The cycle after, GNT=00.
- V0=V1=1 asserted together in IDLE with PTR=0, both sending 2-beat bursts (D0=0x55555555, D1=0xAAAAAAAA) → G0 for two beats, then G1 immediately with no bubble, then PTR=0.
- Backpressure: in G1 hold YR=0 for 20 cycles with V1=1 → R1=0, Y=0xAAAAAAAA stable, no ERR. After YR=1 the beat transfers.
- Stall: TIMEOUT=4, in G0 drop V0 after beat 1 of a 3-beat burst → ERR pulses on the 4th low cycle, then IDLE, PTR=1.
- RST asserted mid-burst in G1 → next cycle IDLE, all outputs at reset values, ERR=0. A new V0 is granted normally.
- Single requester repeats 1-beat bursts every cycle → grant alternates G0/IDLE, one transfer per 2 cycles.

Source files
------------

// File: rtl/mux2x32_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux2x32_arb_pkg
// Shared definitions for the two-requester round-robin arbiter that steers
// the MUX2X32D data path.
//   DATA_W       width of every data bus in the slice
//   DEF_TIMEOUT  default stall timeout, in cycles (legal range 1..255)
//   state_t      arbiter FSM states (IDLE / grant to 0 / grant to 1)
// ---------------------------------------------------------------------------
package mux2x32_arb_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned DEF_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

endpackage

// File: rtl/mux2x32_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux2x32_arbiter_if
// Bundles the two producer handshakes, the consumer handshake and the
// arbiter status outputs.
//   V0/D0/L0, V1/D1/L1  producer valid / data / last-beat (to arbiter)
//   R0, R1              producer ready (from arbiter)
//   Y/YV/YL             consumer data / valid / last (from arbiter)
//   YR                  consumer ready (to arbiter)
//   GNT                 one-hot current grant, 00 when idle
//   ERR                 one-cycle pulse when a stalled burst is revoked
// Modports:
//   master  the surrounding system (producers + consumer)
//   slave   the arbiter itself
// ---------------------------------------------------------------------------
interface mux2x32_arbiter_if;
  import mux2x32_arb_pkg::*;

  logic              V0;
  logic [DATA_W-1:0] D0;
  logic              L0;
  logic              R0;
  logic              V1;
  logic [DATA_W-1:0] D1;
  logic              L1;
  logic              R1;
  logic [DATA_W-1:0] Y;
  logic              YV;
  logic              YL;
  logic              YR;
  logic [1:0]        GNT;
  logic              ERR;

  modport master (
    output V0, D0, L0, V1, D1, L1, YR,
    input  R0, R1, Y, YV, YL, GNT, ERR
  );

  modport slave (
    input  V0, D0, L0, V1, D1, L1, YR,
    output R0, R1, Y, YV, YL, GNT, ERR
  );

endinterface

// File: rtl/mux2x32_arbiter_mux2x32d.sv
// ---------------------------------------------------------------------------
// MUX2X32D
// Plain 2:1 32-bit data multiplexer; the only path from producer data to
// the consumer, so it carries zero latency.
//   A0  data selected when S=0
//   A1  data selected when S=1
//   S   select
//   Y   selected data
// ---------------------------------------------------------------------------
module MUX2X32D
  import mux2x32_arb_pkg::*;
(
  input  logic [DATA_W-1:0] A0,
  input  logic [DATA_W-1:0] A1,
  input  logic              S,
  output logic [DATA_W-1:0] Y
);

  assign Y = S ? A1 : A0;

endmodule

// File: rtl/mux2x32_arbiter.sv
// ---------------------------------------------------------------------------
// mux2x32_arbiter
// Round-robin arbiter sharing one 32-bit consumer port between two
// valid/ready producers. A grant is held for a whole burst (terminated by a
// transferred beat with LAST set); a burst whose owner keeps valid low for
// TIMEOUT consecutive cycles is revoked and ERR pulses.
// Ports:
//   CLK   clock, all state on the rising edge
//   RST   synchronous active-high reset, overrides everything
//   bus   slave side of mux2x32_arbiter_if (handshakes, data, GNT, ERR)
// Parameter:
//   TIMEOUT  stall cycles before revoke, legal range 1..255
// ---------------------------------------------------------------------------
module mux2x32_arbiter
  import mux2x32_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
)
(
  input  logic              CLK,
  input  logic              RST,
  mux2x32_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic             w_ptr_nxt;
  logic [CNT_W-1:0] r_idlecnt;
  logic [CNT_W-1:0] w_idlecnt_nxt;
  logic [1:0]       r_gnt;
  logic             r_err;
  logic             w_err_nxt;

  // Index of the granted requester and its handshake, valid in G states.
  logic             w_gidx;
  logic             w_vn;
  logic             w_ln;
  logic             w_vo;
  logic             w_sel;

  assign w_gidx = (r_state == ST_G1);
  assign w_vn   = w_gidx ? bus.V1 : bus.V0;
  assign w_ln   = w_gidx ? bus.L1 : bus.L0;
  assign w_vo   = w_gidx ? bus.V0 : bus.V1;

  MUX2X32D u_mux (
    .A0 (bus.D0),
    .A1 (bus.D1),
    .S  (w_sel),
    .Y  (bus.Y)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 1'b0;
      r_idlecnt <= '0;
      r_gnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_idlecnt <= w_idlecnt_nxt;
      r_gnt     <= {w_state_nxt == ST_G1, w_state_nxt == ST_G0};
      r_err     <= w_err_nxt;
    end
  end

  // Next state plus the combinational consumer/producer handshake. The idle
  // counter defaults to zero so every state change (entry) clears it; it only
  // survives while the owner stays granted with valid low.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_idlecnt_nxt = '0;
    w_err_nxt     = 1'b0;
    w_sel         = 1'b0;
    bus.YV        = 1'b0;
    bus.YL        = 1'b0;
    bus.R0        = 1'b0;
    bus.R1        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.V0 && bus.V1) begin
          w_state_nxt = r_ptr ? ST_G1 : ST_G0;
        end else if (bus.V0) begin
          w_state_nxt = ST_G0;
        end else if (bus.V1) begin
          w_state_nxt = ST_G1;
        end
      end

      ST_G0, ST_G1: begin
        w_sel  = w_gidx;
        bus.YV = w_vn;
        bus.YL = w_ln;
        bus.R0 = ~w_gidx & bus.YR;
        bus.R1 =  w_gidx & bus.YR;

        if (w_vn && bus.YR && w_ln) begin
          // Burst complete: favour the other side and hand over directly
          // if it is already waiting.
          w_ptr_nxt = ~w_gidx;
          if (w_vo) begin
            w_state_nxt = w_gidx ? ST_G0 : ST_G1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (!w_vn) begin
          if (r_idlecnt == TO_LAST) begin
            w_err_nxt   = 1'b1;
            w_ptr_nxt   = ~w_gidx;
            w_state_nxt = ST_IDLE;
          end else begin
            w_idlecnt_nxt = r_idlecnt + CNT_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.GNT = r_gnt;
  assign bus.ERR = r_err;

endmodule

// File: tb/tb_mux2x32_arbiter.sv
// Self-checking bench for mux2x32_arbiter: directed scenarios followed by
// randomized producers/consumer, all checked against a transaction-level
// model (owner id, favoured id, length of the current stall run).
module tb_mux2x32_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, l0, v1, l1, yr;
  logic [31:0] d0, d1;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: owner -1 = nobody, else requester index.
  int m_own;
  int m_ptr;
  int m_low;
  bit m_err;
  bit x0, x1;

  mux2x32_arbiter_if bus ();

  assign bus.V0 = v0;
  assign bus.D0 = d0;
  assign bus.L0 = l0;
  assign bus.V1 = v1;
  assign bus.D1 = d1;
  assign bus.L1 = l1;
  assign bus.YR = yr;

  mux2x32_arbiter #(.TIMEOUT(TO)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // One clock: check combinational outputs mid-cycle against the model,
  // advance the model with the sampled inputs, then check registered outputs.
  task automatic step();
    logic [31:0] ey;
    logic        eyv, eyl, er0, er1;
    int          nown, nptr, nlow, n;
    bit          nerr, vn, ln, vo;
    #3;
    ey = d0; eyv = 1'b0; eyl = 1'b0; er0 = 1'b0; er1 = 1'b0;
    if (m_own == 0) begin
      ey = d0; eyv = v0; eyl = l0; er0 = yr;
    end else if (m_own == 1) begin
      ey = d1; eyv = v1; eyl = l1; er1 = yr;
    end
    chk("Y",  bus.Y,  ey);
    chk("YV", 32'(bus.YV), 32'(eyv));
    chk("YL", 32'(bus.YL), 32'(eyl));
    chk("R0", 32'(bus.R0), 32'(er0));
    chk("R1", 32'(bus.R1), 32'(er1));

    x0 = (m_own == 0) && v0 && yr;
    x1 = (m_own == 1) && v1 && yr;

    nown = m_own; nptr = m_ptr; nlow = 0; nerr = 1'b0;
    if (rst) begin
      nown = -1; nptr = 0;
    end else if (m_own < 0) begin
      if (v0 && v1) nown = m_ptr;
      else if (v0)  nown = 0;
      else if (v1)  nown = 1;
    end else begin
      n  = m_own;
      vn = (n == 1) ? v1 : v0;
      ln = (n == 1) ? l1 : l0;
      vo = (n == 1) ? v0 : v1;
      if (vn && yr && ln) begin
        nptr = 1 - n;
        nown = vo ? 1 - n : -1;
      end else if (!vn) begin
        nlow = m_low + 1;
        if (nlow == int'(TO)) begin
          nerr = 1'b1; nown = -1; nptr = 1 - n; nlow = 0;
        end
      end
    end

    @(posedge clk);
    m_own = nown; m_ptr = nptr; m_low = nlow; m_err = nerr;
    #1;
    chk("GNT", 32'(bus.GNT), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
    chk("ERR", 32'(bus.ERR), 32'(m_err));
  endtask

  // Protocol-respecting random producers: data/last held while waiting.
  task automatic gen();
    if (!v0) begin
      if ($urandom % 3 == 0) begin v0 = 1'b1; d0 = $urandom; l0 = ($urandom % 3 == 0); end
    end else if (x0) begin
      if ($urandom % 2 == 0) v0 = 1'b0;
      else begin d0 = $urandom; l0 = ($urandom % 3 == 0); end
    end
    if (!v1) begin
      if ($urandom % 3 == 0) begin v1 = 1'b1; d1 = $urandom; l1 = ($urandom % 3 == 0); end
    end else if (x1) begin
      if ($urandom % 2 == 0) v1 = 1'b0;
      else begin d1 = $urandom; l1 = ($urandom % 3 == 0); end
    end
    yr  = ($urandom % 4 != 0);
    rst = ($urandom % 150 == 0);
  endtask

  initial begin
    rst = 1'b1; v0 = 0; l0 = 0; v1 = 0; l1 = 0; yr = 0; d0 = '0; d1 = '0;
    repeat (3) @(posedge clk);
    #1;
    m_own = -1; m_ptr = 0; m_low = 0; m_err = 1'b0;
    chk("rst_gnt", 32'(bus.GNT), 32'd0);
    chk("rst_err", 32'(bus.ERR), 32'd0);
    step();
    rst = 1'b0;

    // Single-beat burst from requester 0.
    v0 = 1; d0 = 32'hFFFF_FFFF; l0 = 1; yr = 1;
    step();
    #1;
    chk("a_y",   bus.Y, 32'hFFFF_FFFF);
    chk("a_r0",  32'(bus.R0), 32'd1);
    chk("a_gnt", 32'(bus.GNT), 32'd1);
    step();
    chk("a_idle", 32'(bus.GNT), 32'd0);
    v0 = 0;
    step();

    // Simultaneous 2-beat bursts, pointer at 0 after reset.
    rst = 1; step(); rst = 0;
    v0 = 1; v1 = 1; d0 = 32'h5555_5555; d1 = 32'hAAAA_AAAA; l0 = 0; l1 = 0;
    step();
    chk("b_gnt0", 32'(bus.GNT), 32'd1);
    step();
    l0 = 1;
    step();
    chk("b_nobubble", 32'(bus.GNT), 32'd2);
    v0 = 0;
    step();
    l1 = 1;
    step();
    chk("b_idle", 32'(bus.GNT), 32'd0);
    v1 = 0;
    step();

    // Backpressure in G1 never counts as a stall.
    v1 = 1; l1 = 0; d1 = 32'hAAAA_AAAA; yr = 0;
    step();
    chk("c_gnt", 32'(bus.GNT), 32'd2);
    for (int i = 0; i < 20; i++) begin
      #1 chk("c_y", bus.Y, 32'hAAAA_AAAA);
      step();
    end
    yr = 1; l1 = 1;
    step();
    chk("c_done", 32'(bus.GNT), 32'd0);
    v1 = 0;

    // Stall timeout in G0 after the first beat of a 3-beat burst.
    v0 = 1; l0 = 0; d0 = 32'h1234_5678;
    step();
    step();
    v0 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("d_noerr", 32'(bus.ERR), 32'd0);
    end
    step();
    chk("d_err",  32'(bus.ERR), 32'd1);
    chk("d_idle", 32'(bus.GNT), 32'd0);
    step();
    chk("d_errpulse", 32'(bus.ERR), 32'd0);
    v0 = 1; v1 = 1; l0 = 1; l1 = 0;
    step();
    chk("d_ptr", 32'(bus.GNT), 32'd2);

    // Reset mid-burst in G1.
    rst = 1;
    step();
    chk("e_gnt", 32'(bus.GNT), 32'd0);
    chk("e_err", 32'(bus.ERR), 32'd0);
    #1 chk("e_yv", 32'(bus.YV), 32'd0);
    rst = 0; v1 = 0; v0 = 1; l0 = 1;
    step();
    chk("e_regrant", 32'(bus.GNT), 32'd1);

    // Back-to-back single beats from one requester alternate G0/IDLE.
    for (int i = 0; i < 6; i++) begin
      step();
      chk("f_alt", 32'(bus.GNT), (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    v0 = 0;
    step();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      gen();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
